// File: rtl/rr_arb_mux_pkg.sv
// rtl/rr_arb_mux_pkg.sv - shared constants, buffer state type and index-width helper for rr_arb_mux
package mux_pkg;

   localparam int MODE_FIXED = 0;
   localparam int MODE_RR    = 1;

   typedef enum logic {
      ST_EMPTY = 1'b0,
      ST_FULL  = 1'b1
   } buf_state_t;

   function automatic int id_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/rr_arb_mux_if.sv
// rtl/rr_arb_mux_if.sv - channel inputs, sink handshake and grant id bundled for rr_arb_mux
interface rr_arb_mux_if #(
   parameter int WIDTH = 32,
   parameter int N_CH  = 2
);
   import mux_pkg::*;

   localparam int ID_W = id_w(N_CH);

   logic [N_CH*WIDTH-1:0] i_data;
   logic [N_CH-1:0]       i_valid;
   logic [N_CH-1:0]       o_ready;
   logic [WIDTH-1:0]      out_data;
   logic                  out_valid;
   logic                  i_ready;
   logic [ID_W-1:0]       o_grant_id;

   modport slave (
      input  i_data, i_valid, i_ready,
      output o_ready, out_data, out_valid, o_grant_id
   );

   modport master (
      output i_data, i_valid, i_ready,
      input  o_ready, out_data, out_valid, o_grant_id
   );

endinterface

// File: rtl/rr_arb_mux_arbiter.sv
// rtl/rr_arb_mux_arbiter.sv - one-hot grant from request vector, fixed priority or rotating start
module rr_arbiter
   import mux_pkg::*;
#(
   parameter int N_CH = 2,
   parameter int MODE = MODE_RR,
   localparam int ID_W = id_w(N_CH)
) (
   input  logic [N_CH-1:0] i_req,
   input  logic [ID_W-1:0] i_ptr,
   output logic [N_CH-1:0] o_grant,
   output logic [ID_W-1:0] o_grant_id
);

   int              w_start;
   int              w_sum;
   logic [ID_W-1:0] w_idx;
   logic            w_found;

   // Fixed priority is the same search anchored at channel 0.
   always_comb begin
      o_grant    = '0;
      o_grant_id = '0;
      w_found    = 1'b0;
      w_sum      = 0;
      w_idx      = '0;
      w_start    = (MODE == MODE_RR) ? int'(i_ptr) : 0;
      for (int off = 0; off < N_CH; off++) begin
         w_sum = w_start + off;
         w_idx = ID_W'((w_sum >= N_CH) ? (w_sum - N_CH) : w_sum);
         if (!w_found && i_req[w_idx]) begin
            w_found        = 1'b1;
            o_grant[w_idx] = 1'b1;
            o_grant_id     = w_idx;
         end
      end
   end

endmodule

// File: rtl/rr_arb_mux.sv
// rtl/rr_arb_mux.sv - N-channel arbitrating mux with a single registered output slot
module rr_arb_mux
   import mux_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int N_CH  = 2,
   parameter int MODE  = MODE_RR,
   localparam int ID_W = id_w(N_CH)
) (
   input  logic         i_clk,
   input  logic         i_rst,
   rr_arb_mux_if.slave  bus
);

   buf_state_t      r_state;
   logic [WIDTH-1:0] r_out_data;
   logic [ID_W-1:0] r_grant_id;
   logic [ID_W-1:0] r_ptr;

   logic [N_CH-1:0]  w_grant;
   logic [ID_W-1:0]  w_grant_id;
   logic [ID_W-1:0]  w_ptr_next;
   logic             w_load_en;
   logic [WIDTH-1:0] w_sel_data;

   rr_arbiter #(
      .N_CH (N_CH),
      .MODE (MODE)
   ) u_arb (
      .i_req      (bus.i_valid),
      .i_ptr      (r_ptr),
      .o_grant    (w_grant),
      .o_grant_id (w_grant_id)
   );

   // A full slot can take a new word only in the cycle the sink drains it.
   assign w_load_en   = (|bus.i_valid) & ((r_state == ST_EMPTY) | bus.i_ready);
   assign bus.o_ready = w_grant & {N_CH{w_load_en}};
   assign w_ptr_next  = (w_grant_id == ID_W'(N_CH - 1)) ? '0 : w_grant_id + 1'b1;

   always_comb begin
      w_sel_data = '0;
      for (int k = 0; k < N_CH; k++) begin
         w_sel_data = w_sel_data | (bus.i_data[k*WIDTH +: WIDTH] & {WIDTH{w_grant[k]}});
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state    <= ST_EMPTY;
         r_out_data <= '0;
         r_grant_id <= '0;
         r_ptr      <= '0;
      end else if (w_load_en) begin
         r_state    <= ST_FULL;
         r_out_data <= w_sel_data;
         r_grant_id <= w_grant_id;
         if (MODE == MODE_RR) begin
            r_ptr <= w_ptr_next;
         end
      end else if ((r_state == ST_FULL) && bus.i_ready) begin
         r_state <= ST_EMPTY;
      end
   end

   assign bus.out_valid  = (r_state == ST_FULL);
   assign bus.out_data   = r_out_data;
   assign bus.o_grant_id = r_grant_id;

endmodule
